// File: rtl/result_frame_tx.sv
// Outbound result framer: on a result pulse, sends HEADER, result bytes LSB first,
// XOR checksum and TRAILER through the UART transmitter's start/ready handshake.
module result_frame_tx #(
  parameter logic [7:0] HEADER      = 8'hA5,
  parameter logic [7:0] TRAILER     = 8'h0D,
  parameter int         NUM_BYTES   = 8,
  parameter int         ACK_TIMEOUT = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] result,
  input  logic        result_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic        busy,
  output logic        done,
  output logic        overrun,
  output logic        timeout_err
);

  localparam int LAST_IDX = NUM_BYTES + 2;
  localparam int IDX_W    = $clog2(LAST_IDX + 1);
  localparam int TMO_W    = $clog2(ACK_TIMEOUT + 1);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LAST_IDX);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [TMO_W-1:0] tmo, tmo_n;
  logic             rdy_p0, rdy_s;
  logic [63:0]      res_q;
  logic [7:0]       chk_q;
  logic             latch;
  logic [7:0]       tx_data_n;
  logic             tx_start_n, busy_n, done_n, overrun_n, timeout_n;

  function automatic logic [7:0] frame_chk(input logic [63:0] r);
    logic [7:0] c;
    c = '0;
    for (int b = 0; b < NUM_BYTES; b++) c = c ^ r[8*b +: 8];
    return c;
  endfunction

  function automatic logic [7:0] frame_byte(input logic [IDX_W-1:0] i,
                                            input logic [63:0]      r,
                                            input logic [7:0]       c);
    logic [7:0] v;
    v = TRAILER;
    if (i == '0) v = HEADER;
    else if (i == IDX_W'(NUM_BYTES + 1)) v = c;
    for (int b = 0; b < NUM_BYTES; b++)
      if (i == IDX_W'(b + 1)) v = r[8*b +: 8];
    return v;
  endfunction

  // Stage p0/s: two-flop synchronizer for the uart_clk-domain ready flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_p0 <= 1'b0;
      rdy_s  <= 1'b0;
    end else begin
      rdy_p0 <= tx_ready;
      rdy_s  <= rdy_p0;
    end
  end

  // Payload and checksum captured once per accepted frame
  always_ff @(posedge clk) begin
    if (latch) begin
      res_q <= result;
      chk_q <= frame_chk(result);
    end
  end

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    tmo_n      = tmo;
    tx_data_n  = tx_data;
    tx_start_n = tx_start;
    busy_n     = busy;
    done_n     = 1'b0;
    timeout_n  = timeout_err;
    latch      = 1'b0;
    // The completion cycle still belongs to the old frame, so a pulse there is an overrun
    overrun_n  = overrun | (result_valid & (busy | done));

    case (state)
      IDLE: begin
        if (result_valid && !done) begin
          latch   = 1'b1;
          idx_n   = '0;
          tmo_n   = '0;
          busy_n  = 1'b1;
          state_n = REQ;
          if (rdy_s) begin
            tx_start_n = 1'b1;
            tx_data_n  = HEADER;
          end
        end
      end
      REQ: begin
        if (!tx_start) begin
          if (rdy_s) begin
            tx_start_n = 1'b1;
            tx_data_n  = frame_byte(idx, res_q, chk_q);
            tmo_n      = '0;
          end
        end else if (!rdy_s) begin
          tx_start_n = 1'b0;
          state_n    = ACK;
        end else if (tmo == TMO_LAST) begin
          tx_start_n = 1'b0;
          timeout_n  = 1'b1;
          busy_n     = 1'b0;
          idx_n      = '0;
          state_n    = IDLE;
        end else begin
          tmo_n = tmo + TMO_ONE;
        end
      end
      ACK: begin
        if (rdy_s) begin
          if (idx == IDX_LAST) begin
            busy_n  = 1'b0;
            done_n  = 1'b1;
            idx_n   = '0;
            state_n = IDLE;
          end else begin
            idx_n      = idx + IDX_ONE;
            tx_start_n = 1'b1;
            tx_data_n  = frame_byte(idx + IDX_ONE, res_q, chk_q);
            tmo_n      = '0;
            state_n    = REQ;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      tmo         <= '0;
      tx_data     <= 8'h00;
      tx_start    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      tmo         <= tmo_n;
      tx_data     <= tx_data_n;
      tx_start    <= tx_start_n;
      busy        <= busy_n;
      done        <= done_n;
      overrun     <= overrun_n;
      timeout_err <= timeout_n;
    end
  end

endmodule

// File: tb/tb_result_frame_tx.sv
// Bench for result_frame_tx: randomized UART-ack model plus a frame-level reference.
module tb_result_frame_tx;
  localparam int         ACK_TIMEOUT = 20000;
  localparam logic [7:0] HEADER      = 8'hA5;
  localparam logic [7:0] TRAILER     = 8'h0D;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] result = '0;
  logic        result_valid = 1'b0;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        tx_start, busy, done, overrun, timeout_err;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int stab_viol = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  bit   xmit_en = 1'b0;
  logic idle_level = 1'b1;

  result_frame_tx #(.HEADER(HEADER), .TRAILER(TRAILER), .NUM_BYTES(8), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .result(result), .result_valid(result_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_start(tx_start), .busy(busy), .done(done),
    .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Transmitter model: takes a byte when start is seen while idle, then is busy a random time
  initial begin
    logic [7:0] cap;
    tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (!xmit_en) tx_ready = idle_level;
      else if (tx_start === 1'b1 && tx_ready === 1'b1) begin
        cap = tx_data;
        rx_q.push_back(cap);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        tx_ready = 1'b0;
        repeat ($urandom_range(5, 12)) @(negedge clk);
        tx_ready = 1'b1;
      end
    end
  end

  // Monitor: done pulses and tx_data changes while a request is held
  logic       prev_start = 1'b0;
  logic [7:0] prev_data = '0;
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (prev_start === 1'b1 && tx_start === 1'b1 && tx_data !== prev_data) stab_viol++;
    prev_start = tx_start;
    prev_data  = tx_data;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic build_expected(input logic [63:0] r);
    logic [7:0] chk;
    exp_q.delete();
    exp_q.push_back(HEADER);
    chk = 8'h00;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(8'((r >> (8 * i)) & 64'hFF));
      chk = chk ^ 8'((r >> (8 * i)) & 64'hFF);
    end
    exp_q.push_back(chk);
    exp_q.push_back(TRAILER);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    result_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_valid(input logic [63:0] r);
    result = r;
    result_valid = 1'b1;
    @(negedge clk);
    result_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok, output int busy_gap);
    ok = 1'b0;
    busy_gap = 0;
    for (int i = 0; i < budget; i++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (busy !== 1'b1) busy_gap++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [12:0] obs;
    rst = 1'b1;
    #1;
    obs = {tx_data, tx_start, busy, done, overrun, timeout_err};
    checks++;
    if (obs !== 13'h0) begin errors++; $display("FAIL reset_outputs: got %h required 0", obs); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    obs = {tx_data, tx_start, busy, done, overrun, timeout_err};
    checks++;
    if (obs !== 13'h0) begin errors++; $display("FAIL reset_idle: got %h required 0", obs); end
  endtask

  task automatic test_basic();
    logic [7:0] req [11] = '{8'hA5, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01, 8'h00, 8'h0D};
    bit ok; int gap; int d0; int sv0;
    do_reset();
    xmit_en = 1'b1;
    rx_q.delete();
    d0 = done_cnt; sv0 = stab_viol;
    pulse_valid(64'h0123456789ABCDEF);
    checks++;
    if ({busy, tx_start, tx_data} !== {1'b1, 1'b1, HEADER}) begin
      errors++; $display("FAIL basic_first_cycle: got busy/start/data %b/%b/%h required 1/1/a5", busy, tx_start, tx_data);
    end
    wait_done(3000, ok, gap);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_done: got no done, required done"); end
    checks++;
    if (gap != 0) begin errors++; $display("FAIL basic_busy: got %0d low cycles, required 0", gap); end
    repeat (20) @(negedge clk);
    checks++;
    if (rx_q.size() != 11) begin errors++; $display("FAIL basic_len: got %0d required 11", rx_q.size()); end
    for (int i = 0; i < 11 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== req[i]) begin errors++; $display("FAIL basic_byte[%0d]: got %h required %h", i, rx_q[i], req[i]); end
    end
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done_count: got %0d required 1", done_cnt - d0); end
    checks++;
    if ({overrun, timeout_err} !== 2'b00 || stab_viol != sv0) begin
      errors++; $display("FAIL basic_flags: got ovr=%b tmo=%b stab=%0d required 0/0/0", overrun, timeout_err, stab_viol - sv0);
    end
  endtask

  task automatic test_checksum();
    logic [7:0] req [11] = '{8'hA5, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h0D};
    bit ok; int gap;
    rx_q.delete();
    pulse_valid(64'h00000000000000FF);
    wait_done(3000, ok, gap);
    checks++;
    if (!ok || rx_q.size() != 11) begin errors++; $display("FAIL chk_frame: got done=%b len=%0d required 1/11", ok, rx_q.size()); end
    for (int i = 0; i < 11 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== req[i]) begin errors++; $display("FAIL chk_byte[%0d]: got %h required %h", i, rx_q[i], req[i]); end
    end
  endtask

  task automatic test_random();
    logic [63:0] r; bit ok; int gap;
    for (int f = 0; f < 4; f++) begin
      repeat ($urandom_range(1, 10)) @(negedge clk);
      r = {$urandom, $urandom};
      build_expected(r);
      rx_q.delete();
      pulse_valid(r);
      wait_done(3000, ok, gap);
      checks++;
      if (!ok || gap != 0) begin errors++; $display("FAIL rand%0d_done: got done=%b gap=%0d required 1/0", f, ok, gap); end
      checks++;
      if (rx_q != exp_q) begin
        errors++; $display("FAIL rand%0d_frame: got %0d bytes (first %h) required %0d bytes for result %h", f, rx_q.size(), rx_q.size() > 0 ? rx_q[0] : 8'h00, exp_q.size(), r);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] r; bit ok; int gap;
    do_reset();
    rx_q.delete();
    pulse_valid({$urandom, $urandom});
    wait_done(3000, ok, gap);
    pulse_valid(64'h1);
    repeat (100) @(negedge clk);
    checks++;
    if (!ok || overrun !== 1'b1 || busy !== 1'b0 || rx_q.size() != 11) begin
      errors++; $display("FAIL done_cycle_overrun: got done=%b ovr=%b busy=%b len=%0d required 1/1/0/11", ok, overrun, busy, rx_q.size());
    end
    r = {$urandom, $urandom};
    pulse_valid(r);
    wait_done(3000, ok, gap);
    @(negedge clk);
    r = {$urandom, $urandom};
    build_expected(r);
    rx_q.delete();
    pulse_valid(r);
    checks++;
    if ({busy, tx_start, tx_data} !== {1'b1, 1'b1, HEADER}) begin
      errors++; $display("FAIL b2b_start: got busy/start/data %b/%b/%h required 1/1/a5", busy, tx_start, tx_data);
    end
    wait_done(3000, ok, gap);
    checks++;
    if (!ok || rx_q != exp_q) begin errors++; $display("FAIL b2b_frame: got done=%b len=%0d required 1/%0d", ok, rx_q.size(), exp_q.size()); end
  endtask

  task automatic test_overrun();
    logic [63:0] r; bit ok; int gap; int d0; int w;
    do_reset();
    rx_q.delete();
    r = {$urandom, $urandom};
    build_expected(r);
    d0 = done_cnt;
    pulse_valid(r);
    w = 0;
    while (rx_q.size() < 4 && w < 2000) begin @(negedge clk); w++; end
    pulse_valid(64'h1);
    wait_done(3000, ok, gap);
    repeat (200) @(negedge clk);
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b required 1", overrun); end
    checks++;
    if (rx_q != exp_q) begin errors++; $display("FAIL ovr_frame: got %0d bytes required %0d unchanged bytes", rx_q.size(), exp_q.size()); end
    checks++;
    if (done_cnt - d0 != 1 || busy !== 1'b0) begin
      errors++; $display("FAIL ovr_second_frame: got done=%0d busy=%b required 1/0", done_cnt - d0, busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [12:0] obs; logic [63:0] r; bit ok; int gap; int w;
    do_reset();
    rx_q.delete();
    pulse_valid({$urandom, $urandom});
    w = 0;
    while (rx_q.size() < 5 && w < 2000) begin @(negedge clk); w++; end
    #2 rst = 1'b1;
    #1;
    obs = {tx_data, tx_start, busy, done, overrun, timeout_err};
    checks++;
    if (obs !== 13'h0) begin errors++; $display("FAIL midreset_outputs: got %h required 0", obs); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    checks++;
    if (rx_q.size() != 5 || tx_start !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL midreset_quiet: got len=%0d start=%b busy=%b required 5/0/0", rx_q.size(), tx_start, busy);
    end
    r = {$urandom, $urandom};
    build_expected(r);
    rx_q.delete();
    pulse_valid(r);
    checks++;
    if ({tx_start, tx_data} !== {1'b1, HEADER}) begin errors++; $display("FAIL midreset_header: got %b/%h required 1/a5", tx_start, tx_data); end
    wait_done(3000, ok, gap);
    checks++;
    if (!ok || rx_q != exp_q) begin errors++; $display("FAIL midreset_frame: got done=%b len=%0d required 1/11", ok, rx_q.size()); end
  endtask

  task automatic test_start_busy();
    logic [63:0] r; bit ok; int gap; int early;
    do_reset();
    xmit_en = 1'b0;
    @(posedge clk); #1 idle_level = 1'b0;
    repeat (5) @(negedge clk);
    r = {$urandom, $urandom};
    build_expected(r);
    rx_q.delete();
    pulse_valid(r);
    early = 0;
    repeat (10) begin
      if (tx_start !== 1'b0 || busy !== 1'b1) early++;
      @(negedge clk);
    end
    checks++;
    if (early != 0) begin errors++; $display("FAIL busy_tx_wait: got %0d bad cycles required 0", early); end
    @(posedge clk); #1 idle_level = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (tx_start !== 1'b0) begin errors++; $display("FAIL busy_tx_sync1: got start=%b required 0", tx_start); end
    @(posedge clk); #1;
    checks++;
    if (tx_start !== 1'b0) begin errors++; $display("FAIL busy_tx_sync2: got start=%b required 0", tx_start); end
    @(posedge clk); #1;
    checks++;
    if ({tx_start, tx_data} !== {1'b1, HEADER}) begin errors++; $display("FAIL busy_tx_rise: got %b/%h required 1/a5", tx_start, tx_data); end
    xmit_en = 1'b1;
    wait_done(3000, ok, gap);
    checks++;
    if (!ok || rx_q != exp_q) begin errors++; $display("FAIL busy_tx_frame: got done=%b len=%0d required 1/11", ok, rx_q.size()); end
  endtask

  task automatic test_timeout();
    int cnt; int d0;
    do_reset();
    xmit_en = 1'b0;
    @(posedge clk); #1 idle_level = 1'b1;
    repeat (5) @(negedge clk);
    d0 = done_cnt;
    pulse_valid({$urandom, $urandom});
    cnt = 0;
    for (int i = 0; i < ACK_TIMEOUT + 50; i++) begin
      if (tx_start !== 1'b1) break;
      cnt++;
      @(negedge clk);
    end
    checks++;
    if (cnt != ACK_TIMEOUT) begin errors++; $display("FAIL tmo_start_len: got %0d required %0d", cnt, ACK_TIMEOUT); end
    checks++;
    if (timeout_err !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL tmo_flags: got tmo=%b busy=%b required 1/0", timeout_err, busy);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (done_cnt != d0 || tx_start !== 1'b0) begin
      errors++; $display("FAIL tmo_no_done: got done=%0d start=%b required 0/0", done_cnt - d0, tx_start);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_checksum();
    test_random();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    test_start_busy();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
